// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: single-port line-granular memory controller.
//
// A requester presents a line read or line write. The controller grants it
// in IDLE, waits LATENCY cycles and then answers with a one-cycle response
// pulse (rvalid_o for reads, write_done_o for writes). Only one transaction
// is ever in flight; requests seen outside IDLE are ignored.
//
// Optional feature, enabled by defining LINE_MEM_RANGE_CHECK_EN:
//   requests with addr_i >= MEM_SIZE still run with normal timing, but
//   flag err_o in their response cycle, read back zero and never write.
//   With the macro undefined err_o is tied low and addresses wrap modulo
//   the number of lines.

package params_pkg;
    localparam int MEM_SIZE   = 1024;
    localparam int ADDR_WIDTH = 16;
endpackage

module line_mem_ctrl #(
    parameter int MEM_SIZE   = params_pkg::MEM_SIZE,
    parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
    parameter int LINE_BYTES = 16,
    parameter int LATENCY    = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [LINE_BYTES*8-1:0] wdata_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [LINE_BYTES*8-1:0] rdata_o,
    output logic                    write_done_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int LINE_BITS = LINE_BYTES * 8;
    localparam int LINES     = MEM_SIZE / LINE_BYTES;
    localparam int OFFS_W    = $clog2(LINE_BYTES);
    localparam int IDX_W     = (LINES > 1) ? $clog2(LINES) : 1;

    // FSM encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] LINES_A   = ADDR_WIDTH'(LINES);

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;

    // Transaction attributes captured at grant
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_BITS-1:0]  wdata_q;
    logic [LINE_BITS-1:0]  rdata_q;

    // Backing store; deliberately not reset
    logic [LINE_BITS-1:0]  mem_q [LINES];

    logic                  grant;
    logic                  enter_resp;
    logic                  txn_we;
    logic [ADDR_WIDTH-1:0] txn_addr;
    logic [LINE_BITS-1:0]  txn_wdata;
    logic                  txn_oor;
    logic [ADDR_WIDTH-1:0] txn_line;
    logic [ADDR_WIDTH-1:0] txn_line_mod;
    logic [IDX_W-1:0]      txn_idx;
    logic [ADDR_WIDTH-1:0] addr_aligned;

    assign grant        = (state_q == S_IDLE) && req_i;
    assign addr_aligned = addr_i & ~OFFS_MASK;

    // Next-state and latency counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY > 1) ? S_BUSY : S_RESP;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                // A counter at or below 1 means the response is due next
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // The edge that enters RESP is where memory is read or written. With
    // LATENCY=1 that edge is also the grant edge, so the transaction fields
    // come straight from the ports instead of the capture registers.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign txn_we     = (state_q == S_IDLE) ? we_i         : we_q;
    assign txn_addr   = (state_q == S_IDLE) ? addr_aligned : addr_q;
    assign txn_wdata  = (state_q == S_IDLE) ? wdata_i      : wdata_q;

    // Line index, wrapping modulo the number of lines
    assign txn_line     = txn_addr >> OFFS_W;
    assign txn_line_mod = txn_line % LINES_A;
    assign txn_idx      = txn_line_mod[IDX_W-1:0];

`ifdef LINE_MEM_RANGE_CHECK_EN
    logic oor_q;
    logic addr_oor;

    assign addr_oor = (64'(addr_i) >= 64'(MEM_SIZE));
    assign txn_oor  = (state_q == S_IDLE) ? addr_oor : oor_q;

    // Remember whether the granted request was out of range
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            oor_q <= 1'b0;
        end else if (grant) begin
            oor_q <= addr_oor;
        end
    end

    assign err_o = (state_q == S_RESP) && oor_q;
`else
    assign txn_oor = 1'b0;
    assign err_o   = 1'b0;
`endif

    // FSM state and latency counter registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the granted request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            we_q    <= we_i;
            addr_q  <= addr_aligned;
            wdata_q <= wdata_i;
        end
    end

    // Registered read data; loaded only by read responses and held otherwise
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (enter_resp && !txn_we) begin
            rdata_q <= txn_oor ? '0 : mem_q[txn_idx];
        end
    end

    // Whole-line write on RESP entry; a reset at that edge drops the write
    always_ff @(posedge clk_i) begin
        if (enter_resp && txn_we && !txn_oor && !rst_i) begin
            mem_q[txn_idx] <= txn_wdata;
        end
    end

    assign gnt_o        = grant && !rst_i;
    assign busy_o       = (state_q != S_IDLE);
    assign rvalid_o     = (state_q == S_RESP) && !we_q;
    assign write_done_o = (state_q == S_RESP) && we_q;
    assign rdata_o      = rdata_q;

endmodule
